// File: rtl/decode_pipe_if.sv
// decode_pipe_if: fetch, write-back and D/E output bundle of decode_pipe
interface decode_pipe_if #(parameter int XLEN = 32);
  logic            in_valid, in_ready;
  logic [31:0]     instr_i;
  logic [XLEN-1:0] pc_i;
  logic            flush_i;
  logic            wb_we_i;
  logic [4:0]      wb_rd_i;
  logic [XLEN-1:0] wb_data_i;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [4:0]      out_rs1, out_rs2, out_rd;
  logic            out_regwrite;
  logic [1:0]      out_resultsrc;
  logic            out_memwrite, out_jump, out_branch;
  logic [3:0]      out_alucontrol;
  logic            out_alusrc, out_illegal;
  modport slave (
    input  in_valid, instr_i, pc_i, flush_i, wb_we_i, wb_rd_i, wb_data_i, out_ready,
    output in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
           out_rs1, out_rs2, out_rd, out_regwrite, out_resultsrc, out_memwrite,
           out_jump, out_branch, out_alucontrol, out_alusrc, out_illegal
  );
  modport master (
    output in_valid, instr_i, pc_i, flush_i, wb_we_i, wb_rd_i, wb_data_i, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
           out_rs1, out_rs2, out_rd, out_regwrite, out_resultsrc, out_memwrite,
           out_jump, out_branch, out_alucontrol, out_alusrc, out_illegal
  );
endinterface

// File: rtl/decode_pipe.sv
// decode_pipe: RV32I decode stage with register file and D/E register; define DECODE_BYPASS_EN to forward write-back data into operand reads
module decode_pipe #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input logic          clk,
  input logic          rst_n,
  decode_pipe_if.slave bus
);
  localparam int RW = $clog2(NREG);
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67;
  localparam logic [6:0] OP_BR = 7'h63, OP_LD = 7'h03, OP_ST = 7'h23, OP_IMM = 7'h13, OP_OP = 7'h33;
  typedef struct packed {
    logic [XLEN-1:0] pc, rs1_data, rs2_data, imm;
    logic [4:0]      rs1, rs2, rd;
    logic            regwrite;
    logic [1:0]      resultsrc;
    logic            memwrite, jump, branch;
    logic [3:0]      alucontrol;
    logic            alusrc, illegal;
  } de_t;
  logic [XLEN-1:0] rf_q [NREG];
  logic [XLEN-1:0] rf_d [NREG];
  de_t de_q, de_d, dec;
  logic valid_q, valid_d, load, hazard, use_rd, use_rs1, use_rs2;
  logic [31:0] ins;
  logic [6:0] opc;
  logic [2:0] f3;
  logic [4:0] rs1, rs2, rd;
  logic [XLEN-1:0] rf1, rf2, rs1_data, rs2_data, imm_i, imm_s, imm_b, imm_j, imm_u;
  function automatic logic ok(input logic [4:0] r);
    return (NREG == 32) || !r[4];
  endfunction
  assign ins = bus.instr_i;
  assign opc = ins[6:0];
  assign f3 = ins[14:12];
  assign rd = ins[11:7];
  assign rs1 = ins[19:15];
  assign rs2 = ins[24:20];
  assign imm_i = XLEN'($signed(ins[31:20]));
  assign imm_s = XLEN'($signed({ins[31:25], ins[11:7]}));
  assign imm_b = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
  assign imm_j = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
  assign imm_u = XLEN'($signed({ins[31:12], 12'h000}));
  assign rf1 = ok(rs1) ? rf_q[rs1[RW-1:0]] : '0;
  assign rf2 = ok(rs2) ? rf_q[rs2[RW-1:0]] : '0;
`ifdef DECODE_BYPASS_EN
  assign rs1_data = (bus.wb_we_i && bus.wb_rd_i != 5'd0 && bus.wb_rd_i == rs1) ? bus.wb_data_i : rf1;
  assign rs2_data = (bus.wb_we_i && bus.wb_rd_i != 5'd0 && bus.wb_rd_i == rs2) ? bus.wb_data_i : rf2;
`else
  assign rs1_data = rf1;
  assign rs2_data = rf2;
`endif
  always_comb begin
    dec = '0;
    {use_rd, use_rs1, use_rs2} = 3'b000;
    dec.pc = bus.pc_i;
    dec.rs1 = rs1;
    dec.rs2 = rs2;
    dec.rd = rd;
    dec.rs1_data = rs1_data;
    dec.rs2_data = rs2_data;
    case (opc)
      OP_LUI:   begin dec.imm = imm_u; dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.alucontrol = 4'hf; use_rd = 1'b1; end
      OP_AUIPC: begin dec.imm = imm_u; dec.regwrite = 1'b1; dec.alusrc = 1'b1; use_rd = 1'b1; end
      OP_JAL:   begin dec.imm = imm_j; dec.regwrite = 1'b1; dec.resultsrc = 2'b10; dec.jump = 1'b1; use_rd = 1'b1; end
      OP_JALR:  begin
        dec.imm = imm_i; dec.regwrite = 1'b1; dec.resultsrc = 2'b10; dec.jump = 1'b1; dec.alusrc = 1'b1;
        {use_rd, use_rs1} = 2'b11;
      end
      OP_BR:    begin
        dec.imm = imm_b; dec.branch = 1'b1; {use_rs1, use_rs2} = 2'b11;
        dec.alucontrol = !f3[2] ? 4'b1000 : f3[1] ? 4'b0011 : 4'b0010;
      end
      OP_LD:    begin
        dec.imm = imm_i; dec.regwrite = 1'b1; dec.resultsrc = 2'b01; dec.alusrc = 1'b1;
        {use_rd, use_rs1} = 2'b11;
      end
      OP_ST:    begin dec.imm = imm_s; dec.memwrite = 1'b1; dec.alusrc = 1'b1; {use_rs1, use_rs2} = 2'b11; end
      OP_IMM:   begin
        dec.imm = imm_i; dec.regwrite = 1'b1; dec.alusrc = 1'b1; {use_rd, use_rs1} = 2'b11;
        dec.alucontrol = {(f3 == 3'b001 || f3 == 3'b101) && ins[30], f3};
      end
      OP_OP:    begin
        dec.regwrite = 1'b1; {use_rd, use_rs1, use_rs2} = 3'b111;
        dec.alucontrol = {(f3 == 3'b000 || f3 == 3'b101) && ins[30], f3};
      end
      default:  dec.illegal = 1'b1;
    endcase
    if ((use_rd && !ok(rd)) || (use_rs1 && !ok(rs1)) || (use_rs2 && !ok(rs2))) dec.illegal = 1'b1;
    if (dec.illegal) {dec.regwrite, dec.resultsrc, dec.memwrite, dec.jump, dec.branch, dec.alucontrol, dec.alusrc} = '0;
  end
  // a load in D/E cannot supply its result to the very next instruction
  assign hazard = valid_q && de_q.resultsrc == 2'b01 && de_q.rd != 5'd0 &&
                  ((use_rs1 && rs1 == de_q.rd) || (use_rs2 && rs2 == de_q.rd));
  assign bus.in_ready = rst_n && (bus.flush_i || ((!valid_q || bus.out_ready) && !hazard));
  always_comb begin
    load = bus.in_valid && bus.in_ready && !bus.flush_i;
    valid_d = !bus.flush_i && (load || (valid_q && !bus.out_ready));
    de_d = load ? dec : de_q;
    rf_d = rf_q;
    if (bus.wb_we_i && bus.wb_rd_i != 5'd0 && ok(bus.wb_rd_i)) rf_d[bus.wb_rd_i[RW-1:0]] = bus.wb_data_i;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      de_q <= '0;
      rf_q <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      de_q <= de_d;
      rf_q <= rf_d;
    end
  end
  assign bus.out_valid = valid_q;
  assign bus.out_pc = de_q.pc;
  assign bus.out_rs1_data = de_q.rs1_data;
  assign bus.out_rs2_data = de_q.rs2_data;
  assign bus.out_imm = de_q.imm;
  assign bus.out_rs1 = de_q.rs1;
  assign bus.out_rs2 = de_q.rs2;
  assign bus.out_rd = de_q.rd;
  assign bus.out_regwrite = de_q.regwrite;
  assign bus.out_resultsrc = de_q.resultsrc;
  assign bus.out_memwrite = de_q.memwrite;
  assign bus.out_jump = de_q.jump;
  assign bus.out_branch = de_q.branch;
  assign bus.out_alucontrol = de_q.alucontrol;
  assign bus.out_alusrc = de_q.alusrc;
  assign bus.out_illegal = de_q.illegal;
endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: vector table, directed corner sequences and random traffic against a spec-level model
module tb_decode_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  decode_pipe_if #(.XLEN(32)) bus ();
  decode_pipe_if #(.XLEN(32)) bus_e ();
  decode_pipe #(.XLEN(32), .NREG(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  decode_pipe #(.XLEN(32), .NREG(16)) dut_e (.clk(clk), .rst_n(rst_n), .bus(bus_e));
`ifdef DECODE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6f, JALR = 7'h67;
  localparam logic [6:0] BR = 7'h63, LD = 7'h03, ST = 7'h23, OPI = 7'h13, OP = 7'h33;
  typedef struct packed {
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        regwrite;
    logic [1:0]  resultsrc;
    logic        memwrite, jump, branch;
    logic [3:0]  aluc;
    logic        alusrc, illegal;
  } dec_t;
  typedef struct {
    logic [31:0] ins, pc, imm;
    logic [4:0]  rd;
    logic [11:0] ctrl;
  } vec_t;
  int n_tests = 0, n_fail = 0;
  logic m_valid = 1'b0;
  dec_t m_out = '0;
  logic [31:0] m_rf [32];
  logic [6:0] pool [12] = '{LUI, AUIPC, JAL, JALR, BR, LD, LD, ST, OPI, OP, OP, 7'h7f};
  vec_t vecs [11];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  function automatic dec_t actual();
    dec_t a;
    a.pc = bus.out_pc; a.rs1d = bus.out_rs1_data; a.rs2d = bus.out_rs2_data; a.imm = bus.out_imm;
    a.rs1 = bus.out_rs1; a.rs2 = bus.out_rs2; a.rd = bus.out_rd; a.regwrite = bus.out_regwrite;
    a.resultsrc = bus.out_resultsrc; a.memwrite = bus.out_memwrite; a.jump = bus.out_jump;
    a.branch = bus.out_branch; a.aluc = bus.out_alucontrol; a.alusrc = bus.out_alusrc; a.illegal = bus.out_illegal;
    return a;
  endfunction
  function automatic logic [11:0] ctrl_of(input dec_t d);
    return {d.regwrite, d.resultsrc, d.memwrite, d.jump, d.branch, d.aluc, d.alusrc, d.illegal};
  endfunction
  // {rd, rs1, rs2} actually used by each format
  function automatic logic [2:0] uses(input logic [31:0] ins);
    case (ins[6:0])
      LUI, AUIPC, JAL: return 3'b100;
      JALR, LD, OPI:   return 3'b110;
      BR, ST:          return 3'b011;
      OP:              return 3'b111;
      default:         return 3'b000;
    endcase
  endfunction
  function automatic dec_t ref_dec(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] r1,
                                   input logic [31:0] r2, input int nreg);
    dec_t d = '0;
    logic [2:0] u = uses(ins);
    logic [2:0] f3 = ins[14:12];
    logic [31:0] ii = 32'($signed(ins[31:20]));
    d.pc = pc; d.rs1 = ins[19:15]; d.rs2 = ins[24:20]; d.rd = ins[11:7]; d.rs1d = r1; d.rs2d = r2;
    case (ins[6:0])
      LUI:   begin d.imm = {ins[31:12], 12'h0}; d.regwrite = 1; d.alusrc = 1; d.aluc = 4'hf; end
      AUIPC: begin d.imm = {ins[31:12], 12'h0}; d.regwrite = 1; d.alusrc = 1; end
      JAL:   begin d.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0})); d.regwrite = 1; d.resultsrc = 2; d.jump = 1; end
      JALR:  begin d.imm = ii; d.regwrite = 1; d.resultsrc = 2; d.jump = 1; d.alusrc = 1; end
      BR:    begin
        d.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0})); d.branch = 1;
        d.aluc = (f3 < 4) ? 4'd8 : (f3 >= 6) ? 4'd3 : 4'd2;
      end
      LD:    begin d.imm = ii; d.regwrite = 1; d.resultsrc = 1; d.alusrc = 1; end
      ST:    begin d.imm = 32'($signed({ins[31:25], ins[11:7]})); d.memwrite = 1; d.alusrc = 1; end
      OPI:   begin d.imm = ii; d.regwrite = 1; d.alusrc = 1; d.aluc = {(f3 == 1 || f3 == 5) && ins[30], f3}; end
      OP:    begin d.regwrite = 1; d.aluc = {(f3 == 0 || f3 == 5) && ins[30], f3}; end
      default: d.illegal = 1;
    endcase
    if (nreg == 16 && ((u[2] && d.rd >= 16) || (u[1] && d.rs1 >= 16) || (u[0] && d.rs2 >= 16))) d.illegal = 1;
    if (d.illegal) begin
      d.regwrite = 0; d.resultsrc = 0; d.memwrite = 0; d.jump = 0; d.branch = 0; d.aluc = 0; d.alusrc = 0;
    end
    return d;
  endfunction
  function automatic logic [31:0] rf_read(input logic [4:0] idx);
    if (BYP && bus.wb_we_i && bus.wb_rd_i != 0 && bus.wb_rd_i == idx) return bus.wb_data_i;
    return m_rf[idx];
  endfunction
  function automatic logic m_hazard(input logic [31:0] ins);
    logic [2:0] u = uses(ins);
    return m_valid && m_out.resultsrc == 2'b01 && m_out.rd != 0 &&
           ((u[1] && ins[19:15] == m_out.rd) || (u[0] && ins[24:20] == m_out.rd));
  endfunction
  task automatic drive(input logic iv, input logic [31:0] ins, input logic [31:0] pc, input logic fl, input logic ordy);
    bus.in_valid = iv; bus.instr_i = ins; bus.pc_i = pc; bus.flush_i = fl; bus.out_ready = ordy;
  endtask
  task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] data);
    bus.wb_we_i = we; bus.wb_rd_i = rd; bus.wb_data_i = data;
  endtask
  // one clock of the random phase: predict in_ready now, then the D/E contents after the edge
  task automatic tick();
    logic rdy, nv;
    dec_t no;
    #1;
    rdy = rst_n && (bus.flush_i || ((!m_valid || bus.out_ready) && !m_hazard(bus.instr_i)));
    chk("rnd in_ready", bus.in_ready, rdy);
    nv = m_valid;
    no = m_out;
    if (!rst_n) begin
      nv = 0; no = '0;
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
    end else begin
      if (bus.flush_i) nv = 0;
      else if (bus.in_valid && rdy) begin
        nv = 1;
        no = ref_dec(bus.instr_i, bus.pc_i, rf_read(bus.instr_i[19:15]), rf_read(bus.instr_i[24:20]), 32);
      end else if (bus.out_ready) nv = 0;
      if (bus.wb_we_i && bus.wb_rd_i != 0) m_rf[bus.wb_rd_i] = bus.wb_data_i;
    end
    cyc();
    m_valid = nv;
    m_out = no;
    chk("rnd out_valid", bus.out_valid, m_valid);
    if (m_valid) chk("rnd payload", actual(), m_out);
  endtask

  initial begin
    logic [31:0] ins;
    vecs[0]  = '{32'hFFB00093, 32'h100, 32'hFFFFFFFB, 5'd1,  12'h802};
    vecs[1]  = '{32'h123453B7, 32'h104, 32'h12345000, 5'd7,  12'h83E};
    vecs[2]  = '{32'hFF9FF0EF, 32'h108, 32'hFFFFFFF8, 5'd1,  12'hC80};
    vecs[3]  = '{32'h00512623, 32'h10C, 32'h0000000C, 5'd12, 12'h102};
    vecs[4]  = '{32'hFE208EE3, 32'h110, 32'hFFFFFFFC, 5'd29, 12'h060};
    vecs[5]  = '{32'h402081B3, 32'h114, 32'h00000000, 5'd3,  12'h820};
    vecs[6]  = '{32'h00012283, 32'h118, 32'h00000000, 5'd5,  12'hA02};
    vecs[7]  = '{32'hFFFFFFFF, 32'h11C, 32'h00000000, 5'd31, 12'h001};
    vecs[8]  = '{32'h4030D113, 32'h120, 32'h00000403, 5'd2,  12'h836};
    vecs[9]  = '{32'hFFFFF517, 32'h124, 32'hFFFFF000, 5'd10, 12'h802};
    vecs[10] = '{32'h00408067, 32'h128, 32'h00000004, 5'd0,  12'hC82};
    drive(0, 0, 0, 0, 0);
    wb(0, 0, 0);
    bus_e.in_valid = 0; bus_e.instr_i = 0; bus_e.pc_i = 0; bus_e.flush_i = 0; bus_e.out_ready = 1;
    bus_e.wb_we_i = 0; bus_e.wb_rd_i = 0; bus_e.wb_data_i = 0;
    rst_n = 0;
    repeat (2) cyc();
    chk("reset in_ready", bus.in_ready, 1'b0);
    chk("reset out_valid", bus.out_valid, 1'b0);
    chk("reset outputs", actual(), 0);
    rst_n = 1;
    #1 chk("in_ready after reset", bus.in_ready, 1'b1);
    // single-instruction decode table, back to back with out_ready=1
    for (int i = 0; i < 11; i++) begin
      drive(1, vecs[i].ins, vecs[i].pc, 0, 1);
      cyc();
      chk($sformatf("vec%0d valid", i), bus.out_valid, 1'b1);
      chk($sformatf("vec%0d pc/imm/rd", i), {bus.out_pc, bus.out_imm, bus.out_rd}, {vecs[i].pc, vecs[i].imm, vecs[i].rd});
      chk($sformatf("vec%0d ctrl", i), ctrl_of(actual()), vecs[i].ctrl);
    end
    drive(0, 0, 0, 0, 1);
    cyc();
    chk("drain out_valid", bus.out_valid, 1'b0);
    // load-use: LW x5,0(x2) then ADD x6,x5,x1
    drive(1, 32'h00012283, 32'h200, 0, 1);
    cyc();
    drive(1, 32'h00128333, 32'h204, 0, 1);
    #1 chk("hazard in_ready", bus.in_ready, 1'b0);
    cyc();
    chk("hazard bubble", bus.out_valid, 1'b0);
    #1 chk("post-bubble in_ready", bus.in_ready, 1'b1);
    cyc();
    chk("add after bubble", {bus.out_valid, bus.out_rd, bus.out_pc}, {1'b1, 5'd6, 32'h204});
    // three-cycle stall
    drive(1, 32'hFFB00093, 32'h300, 0, 1);
    cyc();
    drive(1, 32'h402081B3, 32'h304, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall in_ready", bus.in_ready, 1'b0);
      cyc();
      chk("stall hold", {bus.out_valid, bus.out_pc, bus.out_imm, bus.out_rd}, {1'b1, 32'h300, 32'hFFFFFFFB, 5'd1});
    end
    bus.out_ready = 1;
    #1 chk("stall release in_ready", bus.in_ready, 1'b1);
    cyc();
    chk("stall release load", {bus.out_valid, bus.out_pc}, {1'b1, 32'h304});
    // flush with live input and live D/E
    drive(1, 32'h123453B7, 32'h308, 1, 1);
    #1 chk("flush in_ready", bus.in_ready, 1'b1);
    cyc();
    chk("flush out_valid", bus.out_valid, 1'b0);
    drive(0, 0, 0, 0, 1);
    cyc();
    chk("flush input dropped", bus.out_valid, 1'b0);
    // reset during a stall
    drive(1, 32'hFFB00093, 32'h400, 0, 1);
    cyc();
    drive(1, 32'h402081B3, 32'h404, 0, 0);
    cyc();
    rst_n = 0;
    #1 chk("reset-stall in_ready", bus.in_ready, 1'b0);
    cyc();
    chk("reset-stall cleared", {bus.out_valid, bus.out_pc}, {1'b0, 32'h0});
    rst_n = 1;
    bus.out_ready = 1;
    #1 chk("reset release in_ready", bus.in_ready, 1'b1);
    cyc();
    chk("reset release load", {bus.out_valid, bus.out_pc}, {1'b1, 32'h404});
    // write-back in the same cycle as the read
    drive(1, 32'h00018233, 32'h500, 0, 1);
    wb(1, 3, 32'hDEADBEEF);
    cyc();
    chk("same-cycle wb rs1", bus.out_rs1_data, BYP ? 32'hDEADBEEF : 32'h0);
    drive(1, 32'h00018233, 32'h504, 0, 1);
    wb(1, 0, 32'h12345678);
    cyc();
    chk("wb visible next cycle", bus.out_rs1_data, 32'hDEADBEEF);
    drive(1, 32'h00000233, 32'h508, 0, 1);
    wb(0, 0, 0);
    cyc();
    chk("x0 reads zero", {bus.out_rs1_data, bus.out_rs2_data}, 64'h0);
    drive(0, 0, 0, 0, 1);
    // RV32E register bound
    bus_e.in_valid = 1;
    bus_e.instr_i = 32'h00208A33;
    cyc();
    chk("rv32e x20 illegal", {bus_e.out_valid, bus_e.out_illegal, bus_e.out_regwrite, bus_e.out_memwrite}, 4'b1100);
    bus_e.instr_i = 32'h002087B3;
    cyc();
    chk("rv32e x15 legal", {bus_e.out_valid, bus_e.out_illegal, bus_e.out_regwrite}, 3'b101);
    bus_e.in_valid = 0;
    // random traffic against the model
    rst_n = 0;
    tick();
    rst_n = 1;
    for (int n = 0; n < 600; n++) begin
      ins = $urandom;
      ins[6:0] = pool[$urandom_range(0, 11)];
      ins[11:7] = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      drive($urandom_range(0, 3) != 0, ins, $urandom & 32'hFFFFFFFC, $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
      wb($urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom);
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, data/PC width; legal values 32 and 64.
REQ-002 The block SHALL have parameter NREG, default 32, architectural register count; legal values 32 (RV32I) and 16 (RV32E).
REQ-003 The block SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-005 The block SHALL have port in_valid, input, 1, fetch presents an instruction.
REQ-006 The block SHALL have port in_ready, output, 1, decode accepts this cycle.
REQ-007 The block SHALL have ports instr_i and pc_i, input, 32 and XLEN, instruction and its PC.
REQ-008 The block SHALL have port flush_i, input, 1, poison request from branch resolution.
REQ-009 The block SHALL have ports wb_we_i, wb_rd_i and wb_data_i, input, 1, 5 and XLEN, write-back port.
REQ-010 The block SHALL have port out_valid, output, 1, D/E register holds a live instruction.
REQ-011 The block SHALL have port out_ready, input, 1, execute accepts.
REQ-012 The block SHALL have ports out_pc, out_rs1_data, out_rs2_data and out_imm, output, XLEN each, registered.
REQ-013 The block SHALL have ports out_rs1, out_rs2 and out_rd, output, 5 each, registered.
REQ-014 The block SHALL have registered control outputs: out_regwrite 1, out_resultsrc 2 (00 ALU, 01 mem, 10 PC+4), out_memwrite 1, out_jump 1, out_branch 1, out_alucontrol 4, out_alusrc 1, out_illegal 1.

Function
REQ-015 Register file: NREG x XLEN; x0 reads zero, writes to x0 ignored; written when wb_we_i=1 at clock edge.
REQ-016 D/E load condition: in_ready=1 and in_valid=1; in_ready = (!out_valid | out_ready) & !hazard.
REQ-017 Hold: out_valid=1 and out_ready=0 SHALL keep every output bit-stable.
REQ-018 Drain: out_ready=1 with no load SHALL clear out_valid next cycle.
REQ-019 Latency: one cycle from accepted instr_i to out_valid=1 with decoded fields.
REQ-020 Flush: flush_i=1 SHALL force out_valid=0 next cycle and drop any same-cycle input; priority over load and hold; in_ready reads 1 during flush.
REQ-021 Hazard: hazard=1 when out_valid=1, out_resultsrc=01, out_rd!=0 and out_rd equals a source field actually used by instr_i; the D/E register then loads a bubble (out_valid=0) when out_ready=1.
REQ-022 Immediates sign-extended to XLEN for I, S, B, J formats; U format = instr[31:12]<<12, sign-extended when XLEN=64.
REQ-023 Decode covers RV32I base opcodes (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP).
REQ-024 Any other opcode, or any register index >= NREG, SHALL set out_illegal=1 with out_regwrite=0 and out_memwrite=0.
REQ-025 Simultaneous wb write and read of same register in one cycle SHALL behave per REQ-033/034.

Reset
REQ-026 rst_n=0 at a clock edge SHALL clear out_valid and all registered outputs to 0.
REQ-027 Register file contents SHALL also clear to 0 on reset.
REQ-028 Reset mid-stall or mid-flush SHALL take priority; the first cycle after release accepts input normally.
REQ-029 While rst_n=0, in_ready SHALL read 0.

Configuration
REQ-030 Macro DECODE_BYPASS_EN SHALL select write-back bypass into the register-file read path.
REQ-031 Feature scope is limited to that bypass; no other behaviour depends on the macro.
REQ-032 The macro SHALL NOT alter port list or parameters.
REQ-033 With the macro defined: wb_we_i=1, wb_rd_i!=0 matching rs1/rs2 of the instruction being loaded SHALL forward wb_data_i into out_rs*_data.
REQ-034 Without the macro: the old register value is captured; the new value is visible from the following cycle.

Verification
REQ-035 Reset, then ADDI x1,x0,-5 at pc 0x100, out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFB, out_rd=1, out_alusrc=1, out_pc=0x100.
REQ-036 LW x5,0(x2) then ADD x6,x5,x1 back-to-back -> one cycle in_ready=0, one bubble out_valid=0, ADD issues the cycle after.
REQ-037 out_ready=0 for 3 cycles with valid input -> outputs stable, in_ready=0; out_ready=1 -> next instruction loads.
REQ-038 flush_i=1 while in_valid=1 and out_valid=1 -> out_valid=0 next cycle, input discarded.
REQ-039 wb x3=0xDEADBEEF in same cycle as ADD x4,x3,x0 accepted -> out_rs1_data=0xDEADBEEF with DECODE_BYPASS_EN, 0 without.
REQ-040 NREG=16, ADD x20,x1,x2 -> out_illegal=1, out_regwrite=0.
